// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide unit: one shared 32-step datapath, shift-add for
// multiplies and restoring division for divides, with valid/ready on both sides.
module mul_div_unit #(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned ITERS = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            flush,
   input  logic            valid_in,
   output logic            ready_in,
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] rs1_data,
   input  logic [XLEN-1:0] rs2_data,
   input  logic [4:0]      rd_add,
   output logic            valid_out,
   input  logic            out_ready,
   output logic [XLEN-1:0] result,
   output logic [4:0]      rd_add_out,
   output logic            reg_write
);
   localparam int unsigned CW = $clog2(ITERS);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
   state_t state;

   logic [CW-1:0]     cnt;
   logic [2:0]        op;
   logic              neg_p, neg_r;
   logic [XLEN-1:0]   opnd;
   logic [2*XLEN-1:0] acc, acc_nxt;

   logic              signed_a, signed_b, sa, sb, is_div, div_zero, ovf;
   logic [XLEN-1:0]   a_mag, b_mag, sp_res, final_res;
   logic [XLEN:0]     sum;
   logic [XLEN:0]     shifted;
   logic [XLEN+1:0]   diff;
   logic [2*XLEN-1:0] prod_s;
   logic [XLEN-1:0]   q_s, r_s;

   assign ready_in  = (state == IDLE);
   assign reg_write = valid_out && out_ready && (rd_add_out != 5'd0);

   always_comb begin
      signed_a = (funct3 == 3'd1) || (funct3 == 3'd2) || (funct3 == 3'd4) || (funct3 == 3'd6);
      signed_b = (funct3 == 3'd1) || (funct3 == 3'd4) || (funct3 == 3'd6);
      sa       = signed_a && rs1_data[XLEN-1];
      sb       = signed_b && rs2_data[XLEN-1];
      a_mag    = sa ? (~rs1_data + 1'b1) : rs1_data;
      b_mag    = sb ? (~rs2_data + 1'b1) : rs2_data;
      is_div   = funct3[2];
      div_zero = is_div && (rs2_data == '0);
      ovf      = is_div && !funct3[0] && (rs1_data == {1'b1, {(XLEN-1){1'b0}}})
                 && (rs2_data == '1);
      if (div_zero) sp_res = funct3[1] ? rs1_data : '1;
      else          sp_res = funct3[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
   end

   // acc holds {hi, lo}: product accumulator for multiplies, {remainder, quotient} for divides
   always_comb begin
      sum     = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
      shifted = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
      diff    = {1'b0, shifted} - {2'b00, opnd};
      if (!op[2])       acc_nxt = {sum, acc[XLEN-1:1]};
      else if (diff[XLEN+1]) acc_nxt = {shifted[XLEN-1:0], acc[XLEN-2:0], 1'b0};
      else              acc_nxt = {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
   end

   always_comb begin
      prod_s = neg_p ? (~acc_nxt + 1'b1) : acc_nxt;
      q_s    = neg_p ? (~acc_nxt[XLEN-1:0] + 1'b1) : acc_nxt[XLEN-1:0];
      r_s    = neg_r ? (~acc_nxt[2*XLEN-1:XLEN] + 1'b1) : acc_nxt[2*XLEN-1:XLEN];
      if (op[2])             final_res = op[1] ? r_s : q_s;
      else if (op == 3'd0)   final_res = prod_s[XLEN-1:0];
      else                   final_res = prod_s[2*XLEN-1:XLEN];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         cnt        <= '0;
         op         <= '0;
         neg_p      <= 1'b0;
         neg_r      <= 1'b0;
         opnd       <= '0;
         acc        <= '0;
         result     <= '0;
         rd_add_out <= '0;
         valid_out  <= 1'b0;
      end else if (flush) begin
         state     <= IDLE;
         cnt       <= '0;
         valid_out <= 1'b0;
      end else begin
         case (state)
            IDLE: if (valid_in) begin
               op         <= funct3;
               rd_add_out <= rd_add;
               cnt        <= '0;
               if (div_zero || ovf) begin
                  result    <= sp_res;
                  valid_out <= 1'b1;
                  state     <= DONE;
               end else begin
                  neg_p <= sa ^ sb;
                  neg_r <= is_div && sa;
                  opnd  <= is_div ? b_mag : a_mag;
                  acc   <= {{XLEN{1'b0}}, is_div ? a_mag : b_mag};
                  state <= CALC;
               end
            end
            CALC: begin
               acc <= acc_nxt;
               cnt <= cnt + 1'b1;
               if (cnt == CW'(ITERS-1)) begin
                  result    <= final_res;
                  valid_out <= 1'b1;
                  cnt       <= '0;
                  state     <= DONE;
               end
            end
            DONE: if (out_ready) begin
               valid_out <= 1'b0;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit with a result scoreboard queue and immediate assertions.
module tb_mul_div_unit;
   logic        clk = 1'b0;
   logic        rst_n, flush, valid_in, ready_in, valid_out, out_ready, reg_write;
   logic [2:0]  funct3;
   logic [31:0] rs1_data, rs2_data, result;
   logic [4:0]  rd_add, rd_add_out;

   typedef struct {logic [31:0] res; logic [4:0] rd;} exp_t;
   exp_t sb_q[$];

   int total = 0;
   int bad   = 0;

   mul_div_unit #(.XLEN(32), .ITERS(32)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush), .valid_in(valid_in), .ready_in(ready_in),
      .funct3(funct3), .rs1_data(rs1_data), .rs2_data(rs2_data), .rd_add(rd_add),
      .valid_out(valid_out), .out_ready(out_ready), .result(result),
      .rd_add_out(rd_add_out), .reg_write(reg_write)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd);
      @(negedge clk);
      chk("accept_ready", {31'd0, ready_in}, 32'd1);
      funct3 = f; rs1_data = a; rs2_data = b; rd_add = rd; valid_in = 1'b1;
      @(posedge clk);
      #1 valid_in = 1'b0;
   endtask

   task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input logic [31:0] exp_res);
      exp_t e;
      e.res = exp_res; e.rd = rd;
      sb_q.push_back(e);
      drive(f, a, b, rd);
   endtask

   task automatic wait_out(input string tag, input int exp_lat);
      int   lat;
      exp_t e;
      lat = 0;
      while (!valid_out && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      chk({tag, "_latency"}, lat, exp_lat);
      if (sb_q.size() == 0) begin
         chk({tag, "_scoreboard_empty"}, 32'd1, 32'd0);
      end else begin
         e = sb_q.pop_front();
         chk({tag, "_result"}, result, e.res);
         chk({tag, "_rd"}, {27'd0, rd_add_out}, {27'd0, e.rd});
         chk({tag, "_reg_write"}, {31'd0, reg_write}, {31'd0, out_ready && (e.rd != 5'd0)});
      end
   endtask

   task automatic consume(input string tag);
      @(posedge clk); #1;
      chk({tag, "_vout_drop"}, {31'd0, valid_out}, 32'd0);
      chk({tag, "_ready_back"}, {31'd0, ready_in}, 32'd1);
   endtask

   task automatic op_run(input string tag, input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd, input logic [31:0] exp_res,
                         input int exp_lat);
      issue(f, a, b, rd, exp_res);
      wait_out(tag, exp_lat);
      consume(tag);
   endtask

   initial begin
      logic seen;
      rst_n = 1'b0; flush = 1'b0; valid_in = 1'b0; out_ready = 1'b1;
      funct3 = '0; rs1_data = '0; rs2_data = '0; rd_add = '0;
      #12;
      chk("rst_ready", {31'd0, ready_in}, 32'd1);
      chk("rst_vout", {31'd0, valid_out}, 32'd0);
      chk("rst_regwr", {31'd0, reg_write}, 32'd0);
      chk("rst_result", result, 32'd0);
      chk("rst_rd", {27'd0, rd_add_out}, 32'd0);
      @(negedge clk); rst_n = 1'b1;

      op_run("mul",    3'd0, 32'hFFFFFFFF, 32'd2, 5'd1, 32'hFFFFFFFE, 32);
      op_run("mulh",   3'd1, 32'hFFFFFFFF, 32'd2, 5'd2, 32'hFFFFFFFF, 32);
      op_run("mulhu",  3'd3, 32'hFFFFFFFF, 32'd2, 5'd3, 32'h00000001, 32);
      op_run("mulhsu", 3'd2, 32'hFFFFFFFF, 32'd2, 5'd4, 32'hFFFFFFFF, 32);
      op_run("div",    3'd4, 32'hFFFFFFF9, 32'd2, 5'd5, 32'hFFFFFFFD, 32);
      op_run("rem",    3'd6, 32'hFFFFFFF9, 32'd2, 5'd6, 32'hFFFFFFFF, 32);
      op_run("divu",   3'd5, 32'hFFFFFFF9, 32'd2, 5'd7, 32'h7FFFFFFC, 32);
      op_run("remu",   3'd7, 32'hFFFFFFF9, 32'd2, 5'd8, 32'h00000001, 32);
      op_run("div0",   3'd4, 32'd5, 32'd0, 5'd9,  32'hFFFFFFFF, 0);
      op_run("remu0",  3'd7, 32'd5, 32'd0, 5'd10, 32'd5, 0);
      op_run("divovf", 3'd4, 32'h80000000, 32'hFFFFFFFF, 5'd11, 32'h80000000, 0);
      op_run("removf", 3'd6, 32'h80000000, 32'hFFFFFFFF, 5'd12, 32'd0, 0);
      op_run("divu_r0", 3'd5, 32'd100, 32'd7, 5'd0, 32'd14, 32);

      // backpressure: result held in DONE while out_ready is low
      out_ready = 1'b0;
      issue(3'd0, 32'd7, 32'd6, 5'd13, 32'd42);
      wait_out("bp", 32);
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         chk("bp_vout", {31'd0, valid_out}, 32'd1);
         chk("bp_result", result, 32'd42);
         chk("bp_regwr", {31'd0, reg_write}, 32'd0);
         chk("bp_ready", {31'd0, ready_in}, 32'd0);
      end
      @(negedge clk); out_ready = 1'b1;
      #1 chk("bp_regwr_rel", {31'd0, reg_write}, 32'd1);
      @(posedge clk); #1;
      chk("bp_regwr_after", {31'd0, reg_write}, 32'd0);
      chk("bp_vout_after", {31'd0, valid_out}, 32'd0);
      chk("bp_ready_after", {31'd0, ready_in}, 32'd1);

      // flush at iteration 15
      drive(3'd4, 32'd1000, 32'd3, 5'd14);
      repeat (15) @(posedge clk);
      @(negedge clk); flush = 1'b1;
      @(posedge clk); #1 flush = 1'b0;
      chk("flush_ready", {31'd0, ready_in}, 32'd1);
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         if (valid_out) seen = 1'b1;
      end
      chk("flush_no_vout", {31'd0, seen}, 32'd0);

      // flush together with valid_in in IDLE must not accept
      @(negedge clk);
      funct3 = 3'd0; rs1_data = 32'd3; rs2_data = 32'd3; rd_add = 5'd15;
      valid_in = 1'b1; flush = 1'b1;
      @(posedge clk); #1 valid_in = 1'b0; flush = 1'b0;
      chk("flushvi_ready", {31'd0, ready_in}, 32'd1);
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         if (valid_out) seen = 1'b1;
      end
      chk("flushvi_no_vout", {31'd0, seen}, 32'd0);

      op_run("mul76", 3'd0, 32'd7, 32'd6, 5'd16, 32'd42, 32);

      // async reset mid-CALC of a DIV
      drive(3'd4, 32'd12345, 32'd7, 5'd17);
      repeat (10) @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      chk("arst_vout", {31'd0, valid_out}, 32'd0);
      chk("arst_ready", {31'd0, ready_in}, 32'd1);
      chk("arst_result", result, 32'd0);
      @(negedge clk); rst_n = 1'b1;
      op_run("mul_after_rst", 3'd0, 32'd123, 32'd1000, 5'd18, 32'd123000, 32);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
